// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_pkg
//  Purpose  : Shared constants and types for the bidirectional shift register:
//             default width, shift-direction encoding and the per-edge
//             operation code that drives next-state selection.
//  Revision : 1.0  initial release
// ============================================================================
package shift_reg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Encoding of the shift_left_right input
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Operation performed at a clock edge, listed in priority order
    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_LOAD  = 2'd1,
        OP_SHL   = 2'd2,
        OP_SHR   = 2'd3
    } op_e;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_left_right_reg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_left_right_reg
//  Purpose  : Parallel-load, bidirectional logical shift register. Each rising
//             edge either resets, loads a parallel word, or shifts by one bit
//             (left toward the MSB or right toward the LSB), filling the
//             vacated position with FILL_BIT. Output is a direct flop output.
//  Ports    : reset            - synchronous reset, active-high
//             clk              - rising-edge clock
//             i                - parallel load data, WIDTH bits
//             load_enable      - 1 = load i, 0 = shift
//             shift_left_right - shift direction (0 = left, 1 = right)
//             q                - register contents, WIDTH bits
//  Revision : 1.0  initial release
// ============================================================================
module shift_left_right_reg
    import shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic             FILL_BIT    = 1'b0
) (
    input  logic             reset,
    input  logic             clk,
    input  logic [WIDTH-1:0] i,
    input  logic             load_enable,
    input  logic             shift_left_right,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;
    op_e              op;

    // Priority encode the operation: reset > load > shift
    always_comb begin
        op = OP_SHL;
        if (reset) begin
            op = OP_RESET;
        end else if (load_enable) begin
            op = OP_LOAD;
        end else if (shift_left_right == DIR_RIGHT) begin
            op = OP_SHR;
        end else begin
            op = OP_SHL;
        end
    end

    // Next-state mux; shifts are logical, never rotate or sign-extend
    always_comb begin
        reg_d = reg_q;
        case (op)
            OP_RESET: reg_d = RESET_VALUE;
            OP_LOAD:  reg_d = i;
            OP_SHL:   reg_d = {reg_q[WIDTH-2:0], FILL_BIT};
            OP_SHR:   reg_d = {FILL_BIT, reg_q[WIDTH-1:1]};
            default:  reg_d = reg_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q <= RESET_VALUE;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

    // Reset takes effect on the very next edge regardless of other inputs
    a_reset_value : assert property (@(posedge clk) reset |=> (q == RESET_VALUE));

    // A load places the sampled word on q one edge later
    a_load_value : assert property (@(posedge clk)
        (!reset && load_enable) |=> (q == $past(i)));

endmodule : shift_left_right_reg
`default_nettype wire

// File: tb/tb_shift_left_right_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_left_right_reg
//  Purpose  : Directed-vector bench for shift_left_right_reg (WIDTH = 8).
//             A driver applies one vector per cycle and queues the
//             hand-computed q expected after that edge; a monitor pops and
//             compares after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_left_right_reg;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] i;
    logic         load_enable;
    logic         shift_left_right;
    logic [W-1:0] q;

    shift_left_right_reg #(
        .WIDTH       (W),
        .RESET_VALUE (8'h00),
        .FILL_BIT    (1'b0)
    ) dut (
        .reset            (reset),
        .clk              (clk),
        .i                (i),
        .load_enable      (load_enable),
        .shift_left_right (shift_left_right),
        .q                (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         ld;
        logic         dir;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs [NV];

    logic [W-1:0] exp_q [$];
    int           idx_q [$];
    int           n_pass  = 0;
    int           n_total = 0;

    task automatic set_vec(input int k, input logic r, input logic l,
                           input logic dr, input logic [W-1:0] d,
                           input logic [W-1:0] e);
        vecs[k] = '{rst: r, ld: l, dir: dr, d: d, exp: e};
    endtask

    initial begin
        // reset beats load
        set_vec(0,  1, 1, 0, 8'hFF, 8'h00);
        set_vec(1,  1, 1, 0, 8'hFF, 8'h00);
        // load all ones
        set_vec(2,  0, 1, 0, 8'hFF, 8'hFF);
        // left-shift drain, plus one extra edge holding zero
        set_vec(3,  0, 0, 0, 8'h00, 8'hFE);
        set_vec(4,  0, 0, 0, 8'h00, 8'hFC);
        set_vec(5,  0, 0, 0, 8'h00, 8'hF8);
        set_vec(6,  0, 0, 0, 8'h00, 8'hF0);
        set_vec(7,  0, 0, 0, 8'h00, 8'hE0);
        set_vec(8,  0, 0, 0, 8'h00, 8'hC0);
        set_vec(9,  0, 0, 0, 8'h00, 8'h80);
        set_vec(10, 0, 0, 0, 8'h00, 8'h00);
        set_vec(11, 0, 0, 0, 8'h00, 8'h00);
        // right-shift drain from 1010_1000
        set_vec(12, 0, 1, 0, 8'hA8, 8'hA8);
        set_vec(13, 0, 0, 1, 8'h00, 8'h54);
        set_vec(14, 0, 0, 1, 8'h00, 8'h2A);
        set_vec(15, 0, 0, 1, 8'h00, 8'h15);
        set_vec(16, 0, 0, 1, 8'h00, 8'h0A);
        set_vec(17, 0, 0, 1, 8'h00, 8'h05);
        set_vec(18, 0, 0, 1, 8'h00, 8'h02);
        set_vec(19, 0, 0, 1, 8'h00, 8'h01);
        set_vec(20, 0, 0, 1, 8'h00, 8'h00);
        set_vec(21, 0, 0, 1, 8'h00, 8'h00);
        // direction change; MSB discarded on left, no rotate
        set_vec(22, 0, 1, 0, 8'h81, 8'h81);
        set_vec(23, 0, 0, 0, 8'h00, 8'h02);
        set_vec(24, 0, 0, 1, 8'h00, 8'h01);
        // load wins over shift direction
        set_vec(25, 0, 1, 1, 8'h3C, 8'h3C);
        // no sign extension on right shift of a negative-looking word
        set_vec(26, 0, 1, 0, 8'h80, 8'h80);
        set_vec(27, 0, 0, 1, 8'hFF, 8'h40);
        // mid-operation reset
        set_vec(28, 0, 1, 0, 8'hA8, 8'hA8);
        set_vec(29, 0, 0, 1, 8'h00, 8'h54);
        set_vec(30, 0, 0, 1, 8'h00, 8'h2A);
        set_vec(31, 1, 0, 1, 8'h00, 8'h00);
        set_vec(32, 0, 0, 1, 8'h00, 8'h00);
        set_vec(33, 0, 1, 0, 8'h55, 8'h55);
        set_vec(34, 0, 0, 0, 8'h00, 8'hAA);
        set_vec(35, 0, 0, 1, 8'h00, 8'h55);
        // reset with a pending shift, then alternate direction
        set_vec(36, 1, 0, 0, 8'hFF, 8'h00);
        set_vec(37, 0, 1, 1, 8'hC3, 8'hC3);
    end

    // Driver: apply each vector away from the active edge and queue its result
    initial begin
        reset            = 1'b1;
        i                = '0;
        load_enable      = 1'b0;
        shift_left_right = 1'b0;
        #1;
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            reset            = vecs[k].rst;
            load_enable      = vecs[k].ld;
            shift_left_right = vecs[k].dir;
            i                = vecs[k].d;
            exp_q.push_back(vecs[k].exp);
            idx_q.push_back(k);
        end
        begin
            int waited;
            waited = 0;
            while (exp_q.size() != 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (exp_q.size() != 0) begin
                n_total++;
                $display("FAIL drain_timeout: %0d results still pending, required 0",
                         exp_q.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Monitor: q is valid one edge after each applied vector
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            int           k;
            e = exp_q.pop_front();
            k = idx_q.pop_front();
            n_total++;
            if (q === e) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: q=%h required %h", k, q, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule : tb_shift_left_right_reg
`default_nettype wire
